// File: rtl/ack_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// ack_frame_tx_pkg
// Shared definitions for the acknowledge-frame transmitter:
//   - fixed frame bytes (sync header, tail, NAK code)
//   - status byte bit positions
//   - FSM state encoding
//   - frame checksum and status packing helpers
// Also supplies a default for `UART_FIFO_COUNTER_W when the UART block's
// defines are not part of the build (5 bits covers a 16-entry FIFO, 0..16).
// ---------------------------------------------------------------------------
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package ack_frame_tx_pkg;

    localparam logic [7:0] SYNC0    = 8'hEB;
    localparam logic [7:0] SYNC1    = 8'h90;
    localparam logic [7:0] TAIL0    = 8'h09;
    localparam logic [7:0] TAIL1    = 8'hD7;
    localparam logic [7:0] NAK_CODE = 8'hEE;

    localparam int FRAME_LEN = 8;

    // Status byte: {seq[1:0], overflow, reset_B, reset_A, power_on_B, power_on_A, switch}
    localparam int ST_CPU_LSB = 0;  // five CPU bits, switch at the LSB
    localparam int ST_OVF     = 5;
    localparam int ST_SEQ     = 6;  // two bits

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_SPACE,
        S_PUSH,
        S_GAP,
        S_DONE
    } state_t;

    // CK makes bytes 2..5 of the frame sum to zero modulo 256.
    function automatic logic [7:0] frame_ck(input logic [7:0] id,
                                            input logic [7:0] code,
                                            input logic [7:0] status);
        logic [7:0] sum;
        sum = id + code + status;
        return 8'd0 - sum;
    endfunction

    // cpu = {reset_B, reset_A, power_on_B, power_on_A, switch}
    function automatic logic [7:0] pack_status(input logic [1:0] seq,
                                               input logic       ovf,
                                               input logic [4:0] cpu);
        logic [7:0] s;
        s = '0;
        s[ST_SEQ +: 2]     = seq;
        s[ST_OVF]          = ovf;
        s[ST_CPU_LSB +: 5] = cpu;
        return s;
    endfunction

endpackage

// File: rtl/ack_frame_tx_if.sv
// ---------------------------------------------------------------------------
// ack_frame_tx_if
// Push bus between the frame transmitter and the UART TX FIFO.
//   tf_push  : one-cycle push strobe (master -> FIFO)
//   tdr      : byte to push, valid with tf_push (master -> FIFO)
//   tf_count : current FIFO fill level (FIFO -> master)
// ---------------------------------------------------------------------------
interface ack_frame_tx_if #(
    parameter int COUNT_W = `UART_FIFO_COUNTER_W
);
    logic               tf_push;
    logic [7:0]         tdr;
    logic [COUNT_W-1:0] tf_count;

    modport master (output tf_push, output tdr, input tf_count);
    modport slave  (input tf_push, input tdr, output tf_count);
endinterface

// File: rtl/ack_frame_buf.sv
// ---------------------------------------------------------------------------
// ack_frame_buf
// Eight-byte response frame register. On load it captures the complete
// frame (header, CK, board ID, code, status, tail); idx selects the byte
// presented on data_out.
//   clk      : system clock
//   load     : capture a new frame this cycle
//   code     : byte 4 (command code or NAK)
//   status   : byte 5 (packed status)
//   idx      : byte index 0..7
//   data_out : frame[idx]
// ---------------------------------------------------------------------------
module ack_frame_buf
    import ack_frame_tx_pkg::*;
#(
    parameter logic [7:0] BOARD_ID = 8'hAB
) (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] code,
    input  logic [7:0] status,
    input  logic [2:0] idx,
    output logic [7:0] data_out
);

    logic [7:0] frame [FRAME_LEN];

    // NOTE: the frame array has no reset; it is always rewritten in LOAD
    // before any byte of it can reach the FIFO, so its power-up value is never seen.
    always_ff @(posedge clk) begin
        if (load) begin
            frame[0] <= SYNC0;
            frame[1] <= SYNC1;
            frame[2] <= frame_ck(BOARD_ID, code, status);
            frame[3] <= BOARD_ID;
            frame[4] <= code;
            frame[5] <= status;
            frame[6] <= TAIL0;
            frame[7] <= TAIL1;
        end
    end

    assign data_out = frame[idx];

endmodule

// File: rtl/ack_frame_tx.sv
// ---------------------------------------------------------------------------
// ack_frame_tx
// Builds an 8-byte acknowledge frame for each decoded command and pushes it
// byte-by-byte into the UART TX FIFO, one push every other cycle, only once
// the FIFO has room for the whole frame. One request may wait in a pending
// slot while a frame is in flight; a further one is dropped and flagged.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cmd_done/err/code : decoder result, valid for one cycle
//   switch, power_on_A/B, reset_A/B : board status snapshot inputs
//   tx (master)       : TX FIFO push bus (tf_push, tdr, tf_count)
//   busy              : a frame is being emitted
//   overflow          : sticky, a request was dropped
//
// Build option ACK_NACK_EN: when defined, failed frames are answered with a
// NAK frame (byte 4 = EE); when undefined they are ignored completely.
// ---------------------------------------------------------------------------
module ack_frame_tx
    import ack_frame_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         COUNT_W    = `UART_FIFO_COUNTER_W,
    parameter logic [7:0] BOARD_ID   = 8'hAB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_done,
    input  logic          cmd_err,
    input  logic [7:0]    cmd_code,
    input  logic          switch,
    input  logic          power_on_A,
    input  logic          power_on_B,
    input  logic          reset_A,
    input  logic          reset_B,
    ack_frame_tx_if.master tx,
    output logic          busy,
    output logic          overflow
);

    localparam int MAX_FILL = FIFO_DEPTH - FRAME_LEN;

    state_t state, next_state;

    logic [2:0] idx;
    logic [1:0] seq;

    logic [4:0] live_cpu;
    logic [7:0] cur_code, slot_code;
    logic [4:0] cur_cpu,  slot_cpu;
    logic       slot_full;
`ifdef ACK_NACK_EN
    logic       cur_err, slot_err;
`endif

    logic             req;
    logic             take_cmd, take_slot, to_slot, drop;
    logic             space_ok;
    logic [COUNT_W-1:0] fill;
    logic [7:0]       frame_code;
    logic [7:0]       buf_byte;

    assign live_cpu = {reset_B, reset_A, power_on_B, power_on_A, switch};

`ifdef ACK_NACK_EN
    assign req        = cmd_done;
    assign frame_code = cur_err ? NAK_CODE : cur_code;
`else
    // Failed frames never become requests, so they touch neither slot nor seq.
    assign req        = cmd_done & ~cmd_err;
    assign frame_code = cur_code;
`endif

    assign fill     = tx.tf_count;
    assign space_ok = (int'(fill) <= MAX_FILL);

    // NOTE: always_ff uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        take_cmd   = 1'b0;
        take_slot  = 1'b0;
        case (state)
            S_IDLE: begin
                if (slot_full) begin
                    next_state = S_LOAD;
                    take_slot  = 1'b1;
                end else if (req) begin
                    next_state = S_LOAD;
                    take_cmd   = 1'b1;
                end
            end
            S_LOAD:       next_state = space_ok ? S_PUSH : S_WAIT_SPACE;
            S_WAIT_SPACE: if (space_ok) next_state = S_PUSH;
            // DONE also serves as the idle cycle after the last byte.
            S_PUSH:       next_state = (idx == 3'd7) ? S_DONE : S_GAP;
            S_GAP:        next_state = S_PUSH;
            S_DONE: begin
                if (slot_full) begin
                    next_state = S_LOAD;
                    take_slot  = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default:      next_state = S_IDLE;
        endcase
    end

    // A request not started directly goes to the slot if the slot is empty
    // or is being emptied this very cycle; otherwise it is lost.
    assign to_slot = req & ~take_cmd & (~slot_full | take_slot);
    assign drop    = req & ~take_cmd &  slot_full & ~take_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            seq       <= '0;
            overflow  <= 1'b0;
            slot_full <= 1'b0;
            slot_code <= '0;
            slot_cpu  <= '0;
            cur_code  <= '0;
            cur_cpu   <= '0;
`ifdef ACK_NACK_EN
            slot_err  <= 1'b0;
            cur_err   <= 1'b0;
`endif
        end else begin
            if (state == S_LOAD)      idx <= '0;
            else if (state == S_GAP)  idx <= idx + 3'd1;

            if (state == S_DONE) seq <= seq + 2'd1;

            if (drop) overflow <= 1'b1;

            if (take_cmd) begin
                cur_code <= cmd_code;
                cur_cpu  <= live_cpu;
`ifdef ACK_NACK_EN
                cur_err  <= cmd_err;
`endif
            end else if (take_slot) begin
                cur_code <= slot_code;
                cur_cpu  <= slot_cpu;
`ifdef ACK_NACK_EN
                cur_err  <= slot_err;
`endif
            end

            if (to_slot) begin
                slot_full <= 1'b1;
                slot_code <= cmd_code;
                slot_cpu  <= live_cpu;
`ifdef ACK_NACK_EN
                slot_err  <= cmd_err;
`endif
            end else if (take_slot) begin
                slot_full <= 1'b0;
            end
        end
    end

    // seq and overflow enter the status byte as of LOAD, so a drop during
    // the previous frame shows up in the next one.
    ack_frame_buf #(.BOARD_ID(BOARD_ID)) u_buf (
        .clk      (clk),
        .load     (state == S_LOAD),
        .code     (frame_code),
        .status   (pack_status(seq, overflow, cur_cpu)),
        .idx      (idx),
        .data_out (buf_byte)
    );

    assign tx.tf_push = (state == S_PUSH);
    assign tx.tdr     = (state == S_PUSH) ? buf_byte : 8'h00;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_ack_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_ack_frame_tx
// Directed bench for ack_frame_tx. Inputs are driven on the falling edge and
// outputs sampled on the falling edge; a monitor logs every push (byte and
// cycle number) and the busy level per cycle.
// ---------------------------------------------------------------------------
module tb_ack_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_done, cmd_err;
    logic [7:0] cmd_code;
    logic       switch, power_on_A, power_on_B, reset_A, reset_B;
    logic       busy, overflow;

    ack_frame_tx_if #(.COUNT_W(`UART_FIFO_COUNTER_W)) tx_if ();

    ack_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .cmd_code   (cmd_code),
        .switch     (switch),
        .power_on_A (power_on_A),
        .power_on_B (power_on_B),
        .reset_A    (reset_A),
        .reset_B    (reset_B),
        .tx         (tx_if.master),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] push_q [$];
    int         pcyc_q [$];
    bit         prev_push = 1'b0;
    bit         busy_log [int];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        busy_log[cyc] = busy;
        if (tx_if.tf_push) begin
            push_q.push_back(tx_if.tdr);
            pcyc_q.push_back(cyc);
            checks++;
            if (prev_push) begin
                failures++;
                $display("FAIL push_gap: tf_push=1 at cycles %0d and %0d, required a gap", cyc - 1, cyc);
            end
        end
        prev_push = tx_if.tf_push;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, required $finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        push_q.delete();
        pcyc_q.delete();
    endtask

    task automatic set_stat(input bit sw, input bit pa, input bit pb, input bit ra, input bit rb);
        switch = sw; power_on_A = pa; power_on_B = pb; reset_A = ra; reset_B = rb;
    endtask

    // Pulses cmd_done in the current cycle n; returns at the negedge of n+1.
    task automatic send(input logic [7:0] code, input bit err, output int n);
        n        = cyc;
        cmd_done = 1'b1;
        cmd_code = code;
        cmd_err  = err;
        @(negedge clk);
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_q();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        if (tx_if.tf_push !== 1'b0) begin failures++; $display("FAIL reset_tf_push: got %b want 0", tx_if.tf_push); end
        if (tx_if.tdr !== 8'h00)    begin failures++; $display("FAIL reset_tdr: got %02h want 00", tx_if.tdr); end
        if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (overflow !== 1'b0)      begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks += 4;
        rst = 1'b0;
        tick(1);
        clear_q();
    endtask

    task automatic test_basic();
        logic [7:0] exp [8] = '{8'hEB, 8'h90, 8'h45, 8'hAB, 8'h0A, 8'h06, 8'h09, 8'hD7};
        int n;
        set_stat(0, 1, 1, 0, 0);
        send(8'h0A, 1'b0, n);
        tick(25);
        checks++;
        if (push_q.size() != 8) begin
            failures++; $display("FAIL basic_count: got %0d pushes want 8", push_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks += 2;
                if (push_q[k] !== exp[k]) begin failures++; $display("FAIL basic_byte%0d: got %02h want %02h", k, push_q[k], exp[k]); end
                if (pcyc_q[k] != n + 2 + 2*k) begin failures++; $display("FAIL basic_cycle%0d: got N+%0d want N+%0d", k, pcyc_q[k] - n, 2 + 2*k); end
            end
        end
        checks += 5;
        if (busy_log[n] !== 1'b0)      begin failures++; $display("FAIL basic_busy_N: got 1 want 0"); end
        if (busy_log[n+1] !== 1'b1)    begin failures++; $display("FAIL basic_busy_N1: got 0 want 1"); end
        if (busy_log[n+17] !== 1'b1)   begin failures++; $display("FAIL basic_busy_N17: got 0 want 1"); end
        if (busy_log[n+18] !== 1'b0)   begin failures++; $display("FAIL basic_busy_N18: got 1 want 0"); end
        if (tx_if.tdr !== 8'h00)       begin failures++; $display("FAIL basic_tdr_idle: got %02h want 00", tx_if.tdr); end
        clear_q();
    endtask

    // seq is 1 here; status = 0x46, CK = D3.
    task automatic test_wait_space();
        int n;
        tx_if.tf_count = 9;
        send(8'h3C, 1'b0, n);
        for (int i = 0; i < 40 && cyc < n + 20; i++) tick(1);
        tx_if.tf_count = 8;
        tick(30);
        tx_if.tf_count = 0;
        checks += 2;
        if (busy_log[n+19] !== 1'b1) begin failures++; $display("FAIL wait_busy: got 0 want 1 while waiting"); end
        if (push_q.size() != 8) begin
            failures++; $display("FAIL wait_count: got %0d pushes want 8", push_q.size());
        end else begin
            checks += 5;
            if (pcyc_q[0] != n + 21) begin failures++; $display("FAIL wait_first_cycle: got N+%0d want N+21", pcyc_q[0] - n); end
            if (pcyc_q[7] != n + 35) begin failures++; $display("FAIL wait_last_cycle: got N+%0d want N+35", pcyc_q[7] - n); end
            if (push_q[2] !== 8'hD3) begin failures++; $display("FAIL wait_ck: got %02h want D3", push_q[2]); end
            if (push_q[4] !== 8'h3C) begin failures++; $display("FAIL wait_code: got %02h want 3C", push_q[4]); end
            if (push_q[5] !== 8'h46) begin failures++; $display("FAIL wait_status: got %02h want 46", push_q[5]); end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [16] = '{8'hEB, 8'h90, 8'h41, 8'hAB, 8'h11, 8'h03, 8'h09, 8'hD7,
                                 8'hEB, 8'h90, 8'hD0, 8'hAB, 8'h22, 8'h63, 8'h09, 8'hD7};
        int n, m, p;
        do_reset();
        set_stat(1, 1, 0, 0, 0);
        send(8'h11, 1'b0, n);
        tick(1);
        send(8'h22, 1'b0, m);
        set_stat(0, 1, 0, 0, 0);   // must not alter the snapshot already in the slot
        tick(1);
        send(8'h33, 1'b0, p);
        tick(45);
        checks += 3;
        if (overflow !== 1'b1)        begin failures++; $display("FAIL b2b_overflow: got %b want 1", overflow); end
        if (busy_log[n+18] !== 1'b1)  begin failures++; $display("FAIL b2b_busy_join: got 0 want 1"); end
        if (push_q.size() != 16) begin
            failures++; $display("FAIL b2b_count: got %0d pushes want 16", push_q.size());
        end else begin
            if (pcyc_q[8] != n + 19) begin failures++; $display("FAIL b2b_second_start: got N+%0d want N+19", pcyc_q[8] - n); end
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (push_q[k] !== exp[k]) begin failures++; $display("FAIL b2b_byte%0d: got %02h want %02h", k, push_q[k], exp[k]); end
            end
        end
        clear_q();
    endtask

    task automatic test_nack();
        int n;
        do_reset();
        set_stat(0, 0, 0, 0, 0);
        send(8'h55, 1'b1, n);
        tick(25);
`ifdef ACK_NACK_EN
        checks++;
        if (push_q.size() != 8) begin
            failures++; $display("FAIL nack_count: got %0d pushes want 8", push_q.size());
        end else begin
            checks += 3;
            if (push_q[4] !== 8'hEE) begin failures++; $display("FAIL nack_code: got %02h want EE", push_q[4]); end
            if (push_q[2] !== 8'h67) begin failures++; $display("FAIL nack_ck: got %02h want 67", push_q[2]); end
            if (8'(push_q[2] + push_q[3] + push_q[4] + push_q[5]) !== 8'h00) begin
                failures++; $display("FAIL nack_sum: got %02h want 00", 8'(push_q[2] + push_q[3] + push_q[4] + push_q[5]));
            end
        end
`else
        begin
            bit any_busy;
            any_busy = 1'b0;
            for (int c = n; c <= n + 25; c++) if (busy_log.exists(c) && busy_log[c]) any_busy = 1'b1;
            checks += 3;
            if (push_q.size() != 0) begin failures++; $display("FAIL nack_ignored_push: got %0d pushes want 0", push_q.size()); end
            if (any_busy)           begin failures++; $display("FAIL nack_ignored_busy: got 1 want 0"); end
            if (overflow !== 1'b0)  begin failures++; $display("FAIL nack_ignored_ovf: got %b want 0", overflow); end
        end
        clear_q();
        send(8'h01, 1'b0, n);
        tick(20);
        checks++;
        if (push_q.size() != 8 || push_q[5] !== 8'h00) begin
            failures++; $display("FAIL nack_seq_kept: got %0d pushes status %02h want 8 pushes status 00",
                                 push_q.size(), (push_q.size() > 5) ? push_q[5] : 8'hXX);
        end
`endif
        clear_q();
    endtask

    task automatic test_seq_wrap();
        logic [7:0] exp_st [5] = '{8'h02, 8'h42, 8'h82, 8'hC2, 8'h02};
        int n;
        do_reset();
        set_stat(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] code, ck;
            code = 8'(k + 1);
            ck   = 8'd0 - 8'(8'hAB + code + exp_st[k]);
            send(code, 1'b0, n);
            tick(20);
            checks++;
            if (push_q.size() != 8) begin
                failures++; $display("FAIL seq%0d_count: got %0d pushes want 8", k, push_q.size());
            end else begin
                checks += 2;
                if (push_q[5] !== exp_st[k]) begin failures++; $display("FAIL seq%0d_status: got %02h want %02h", k, push_q[5], exp_st[k]); end
                if (push_q[2] !== ck)        begin failures++; $display("FAIL seq%0d_ck: got %02h want %02h", k, push_q[2], ck); end
            end
            clear_q();
        end
    endtask

    // Second cmd_done lands exactly in the DONE cycle of the first frame.
    task automatic test_done_edge();
        int n, m;
        send(8'hA1, 1'b0, n);
        tick(16);
        send(8'hA2, 1'b0, m);
        tick(40);
        checks++;
        if (push_q.size() != 16) begin
            failures++; $display("FAIL done_edge_count: got %0d pushes want 16", push_q.size());
        end else begin
            checks += 3;
            if (m != n + 17)            begin failures++; $display("FAIL done_edge_align: got N+%0d want N+17", m - n); end
            if (push_q[12] !== 8'hA2)   begin failures++; $display("FAIL done_edge_code: got %02h want A2", push_q[12]); end
            if (pcyc_q[8] != n + 20)    begin failures++; $display("FAIL done_edge_start: got N+%0d want N+20", pcyc_q[8] - n); end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int n, m, p;
        send(8'h77, 1'b0, n);
        tick(2);
        send(8'h78, 1'b0, m);
        tick(1);
        send(8'h79, 1'b0, p);
        tick(2);                       // now in cycle N+8, the 4th push
        checks += 2;
        if (tx_if.tf_push !== 1'b1) begin failures++; $display("FAIL rstmid_push4: got %b want 1", tx_if.tf_push); end
        if (overflow !== 1'b1)      begin failures++; $display("FAIL rstmid_ovf_before: got %b want 1", overflow); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(25);
        checks += 4;
        if (push_q.size() != 4)      begin failures++; $display("FAIL rstmid_count: got %0d pushes want 4", push_q.size()); end
        if (busy_log[n+9] !== 1'b0)  begin failures++; $display("FAIL rstmid_busy: got 1 want 0"); end
        if (busy !== 1'b0)           begin failures++; $display("FAIL rstmid_busy_after: got 1 want 0 (pending not discarded)"); end
        if (overflow !== 1'b0)       begin failures++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
        clear_q();
        send(8'h5A, 1'b0, n);
        tick(20);
        checks++;
        if (push_q.size() != 8 || push_q[5] !== 8'h02) begin
            failures++; $display("FAIL rstmid_next_seq: got %0d pushes status %02h want 8 pushes status 02",
                                 push_q.size(), (push_q.size() > 5) ? push_q[5] : 8'hXX);
        end
        clear_q();
    endtask

    initial begin
        rst = 1'b1; cmd_done = 1'b0; cmd_err = 1'b0; cmd_code = 8'h00;
        set_stat(0, 0, 0, 0, 0);
        tx_if.tf_count = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wait_space();
        test_back_to_back();
        test_nack();
        test_seq_wrap();
        test_done_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
